// File: rtl/l2k_cache_fill.sv
`default_nettype none
// ============================================================================
// Module   : l2k_cache_fill
// Purpose  : Request-side controller for a hashed direct-mapped L2 data array.
//            Looks up single-word core reads against an internal tag store.
//            A hit returns the array word. A miss fetches the word from memory
//            over a valid/ready handshake, writes it into the array, and then
//            responds. A memory timeout produces an error response.
// Ports    : clk/rst                  - clock, synchronous active-high reset
//            req_* / resp_*           - core request and one-cycle response
//            inv                      - invalidate every tag
//            cache_*                  - L2 array write port and combinational
//                                       read port
//            mem_req_* / mem_resp_*   - memory read request and read data
//            hit_count / miss_count   - saturating statistics counters
// Revision : 1.0 - initial release
// ============================================================================
module l2k_cache_fill #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 512,
  parameter int TIMEOUT     = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  input  logic [31:0]           req_addr,
  output logic                  req_ready,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  resp_hit,
  output logic                  resp_err,
  input  logic                  inv,
  output logic                  cache_we,
  output logic [31:0]           cache_addr_in,
  output logic [DATA_WIDTH-1:0] cache_data_in,
  output logic [31:0]           cache_addr_out,
  input  logic [DATA_WIDTH-1:0] cache_data_out,
  output logic                  mem_req_valid,
  output logic [31:0]           mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] mem_resp_data,
  output logic [15:0]           hit_count,
  output logic [15:0]           miss_count
);

  localparam int          c_IDX_W   = $clog2(NUM_ENTRIES);
  localparam logic [15:0] c_TIMEOUT = TIMEOUT[15:0];
  localparam logic [15:0] c_SAT     = 16'hFFFF;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_FILL     = 3'd4,
    S_RESP     = 3'd5
  } state_t;

  // Integer avalanche hash; only the low index bits select the slot.
  function automatic logic [c_IDX_W-1:0] slot_of(input logic [31:0] x);
    logic [31:0] h;
    h = ((x >> 16) ^ x) * 32'h045D9F3B;
    h = ((h >> 16) ^ h) * 32'h045D9F3B;
    h = (h >> 16) ^ h;
    return h[c_IDX_W-1:0];
  endfunction

  state_t                  state_q;
  logic [31:0]             addr_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [15:0]             wait_q;
  logic [15:0]             hit_q;
  logic [15:0]             miss_q;
  logic                    req_ready_q;
  logic                    resp_valid_q;
  logic                    resp_hit_q;
  logic                    resp_err_q;
  logic                    cache_we_q;
  logic                    mem_req_valid_q;
  logic [NUM_ENTRIES-1:0]  valid_q;
  logic [31:0]             tag_q [NUM_ENTRIES];

  logic [c_IDX_W-1:0]      w_idx;
  logic                    w_hit;

  // Address is held for the whole transaction, so the slot is derived from it.
  assign w_idx = slot_of(addr_q);
  assign w_hit = valid_q[w_idx] && (tag_q[w_idx] == addr_q);

  // Tag payload carries no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!rst && state_q == S_FILL) begin
      tag_q[w_idx] <= addr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      data_q          <= '0;
      wait_q          <= '0;
      hit_q           <= '0;
      miss_q          <= '0;
      req_ready_q     <= 1'b1;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_err_q      <= 1'b0;
      cache_we_q      <= 1'b0;
      mem_req_valid_q <= 1'b0;
      valid_q         <= '0;
    end else begin
      // Single-cycle pulses default low every cycle.
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_err_q   <= 1'b0;
      cache_we_q   <= 1'b0;

      // Invalidate applies in any state; a coincident fill re-validates its
      // own slot further down, so the fill wins for that slot only.
      if (inv) begin
        valid_q <= '0;
      end

      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q      <= req_addr;
            req_ready_q <= 1'b0;
            state_q     <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          if (w_hit) begin
            data_q       <= cache_data_out;
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            if (hit_q != c_SAT) hit_q <= hit_q + 16'd1;
            state_q      <= S_RESP;
          end else begin
            mem_req_valid_q <= 1'b1;
            if (miss_q != c_SAT) miss_q <= miss_q + 16'd1;
            state_q         <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            wait_q          <= '0;
            state_q         <= S_MEM_WAIT;
          end
        end
        S_MEM_WAIT: begin
          if (mem_resp_valid) begin
            data_q     <= mem_resp_data;
            cache_we_q <= 1'b1;
            state_q    <= S_FILL;
          end else if (wait_q + 16'd1 == c_TIMEOUT) begin
            // Give up: error response with zero data, nothing is filled.
            data_q       <= '0;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            wait_q <= wait_q + 16'd1;
          end
        end
        S_FILL: begin
          valid_q[w_idx] <= 1'b1;
          resp_valid_q   <= 1'b1;
          state_q        <= S_RESP;
        end
        S_RESP: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
        default: begin
          req_ready_q <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_data      = data_q;
  assign resp_hit       = resp_hit_q;
  assign resp_err       = resp_err_q;
  assign cache_we       = cache_we_q;
  assign cache_addr_in  = addr_q;
  assign cache_data_in  = data_q;
  assign cache_addr_out = addr_q;
  assign mem_req_valid  = mem_req_valid_q;
  assign mem_req_addr   = addr_q;
  assign hit_count      = hit_q;
  assign miss_count     = miss_q;

endmodule
`default_nettype wire

// File: tb/tb_l2k_cache_fill.sv
`default_nettype none
// ============================================================================
// Module   : tb_l2k_cache_fill
// Purpose  : Self-checking bench for l2k_cache_fill. Models the L2 array as a
//            plain address-keyed memory and the cache as a slot->address map,
//            drives memory handshakes with configurable delays, and compares
//            every response, fill and counter against that model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_l2k_cache_fill;

  localparam int DW = 32;
  localparam int NE = 16;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic [31:0]   req_addr = '0;
  logic          req_ready;
  logic          resp_valid;
  logic [DW-1:0] resp_data;
  logic          resp_hit;
  logic          resp_err;
  logic          inv = 1'b0;
  logic          cache_we;
  logic [31:0]   cache_addr_in;
  logic [DW-1:0] cache_data_in;
  logic [31:0]   cache_addr_out;
  logic [DW-1:0] cache_data_out = '0;
  logic          mem_req_valid;
  logic [31:0]   mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_resp_valid = 1'b0;
  logic [DW-1:0] mem_resp_data = '0;
  logic [15:0]   hit_count;
  logic [15:0]   miss_count;

  always #5 clk = ~clk;

  l2k_cache_fill #(.DATA_WIDTH(DW), .NUM_ENTRIES(NE), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_hit(resp_hit), .resp_err(resp_err),
    .inv(inv),
    .cache_we(cache_we), .cache_addr_in(cache_addr_in), .cache_data_in(cache_data_in),
    .cache_addr_out(cache_addr_out), .cache_data_out(cache_data_out),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
    .hit_count(hit_count), .miss_count(miss_count)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: which address each slot holds, and its data.
  logic [31:0] m_tag  [int];
  logic [31:0] m_data [int];
  int          m_hits = 0;
  int          m_misses = 0;
  // External L2 array contents, keyed by full address.
  logic [31:0] l2_arr [logic [31:0]];

  typedef struct {
    int          lat;        // edges after acceptance until resp_valid seen
    logic [31:0] data;
    logic        hit;
    logic        err;
    int          resp_n;
    int          we_n;
    logic [31:0] we_addr;
    logic [31:0] we_data;
    int          mreq_n;
    logic [31:0] mreq_addr;
    bit          mreq_stable;
  } obs_t;

  function automatic int ref_idx(input logic [31:0] x);
    logic [31:0] a;
    a = ((x >> 16) ^ x) * 32'h045D9F3B;
    a = ((a >> 16) ^ a) * 32'h045D9F3B;
    a = (a >> 16) ^ a;
    return int'(a % NE);
  endfunction

  function automatic logic [31:0] arr_rd(input logic [31:0] a);
    if (l2_arr.exists(a)) return l2_arr[a];
    return 32'h0;
  endfunction

  // Predict the outcome of a request and advance the model.
  // mdly: memory answers mdly edges after accepting the request; 0 = never.
  task automatic m_apply(input logic [31:0] a, input int rdy, input int mdly,
                         input logic [31:0] md, input bit inv_fill,
                         output bit e_hit, output bit e_err,
                         output logic [31:0] e_data, output int e_lat);
    int i;
    i = ref_idx(a);
    if (m_tag.exists(i) && m_tag[i] == a) begin
      e_hit = 1; e_err = 0; e_data = m_data[i]; e_lat = 1;
      if (m_hits < 65535) m_hits++;
    end else begin
      e_hit = 0;
      if (m_misses < 65535) m_misses++;
      if (mdly >= 1 && mdly <= TO) begin
        e_err = 0; e_data = md; e_lat = rdy + mdly + 3;
        if (inv_fill) begin m_tag.delete(); m_data.delete(); end
        m_tag[i] = a; m_data[i] = md;
      end else begin
        e_err = 1; e_data = 32'h0; e_lat = rdy + 2 + TO;
      end
    end
  endtask

  // Issue one request from IDLE and record everything seen on the ports.
  // Entry/exit point: 1 time unit after a rising edge.
  task automatic run_req(input logic [31:0] addr, input int rdy_lat, input int mdly,
                         input logic [31:0] mdata, input bit noise, input bit inv_fill,
                         output obs_t o);
    int  mseen;
    int  j;
    bit  acc_pending;
    o.lat = -1; o.data = '0; o.hit = 0; o.err = 0; o.resp_n = 0; o.we_n = 0;
    o.we_addr = '0; o.we_data = '0; o.mreq_n = 0; o.mreq_addr = '0; o.mreq_stable = 1;
    mseen = 0; j = -1; acc_pending = 0;
    req_valid = 1'b1; req_addr = addr;
    @(posedge clk); #1;
    req_valid = 1'b0; req_addr = $urandom;
    cache_data_out = arr_rd(cache_addr_out);
    if (noise) begin mem_resp_valid = 1'b1; mem_resp_data = $urandom; end
    for (int k = 1; k <= 60; k++) begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      mem_req_ready  = 1'b0;
      inv            = 1'b0;
      if (acc_pending) begin j = 0; acc_pending = 0; end
      else if (j >= 0) j++;
      if (cache_we) begin
        o.we_n++; o.we_addr = cache_addr_in; o.we_data = cache_data_in;
        l2_arr[cache_addr_in] = cache_data_in;
        if (inv_fill) inv = 1'b1;
      end
      if (resp_valid) begin
        o.resp_n++;
        if (o.lat < 0) begin
          o.lat = k; o.data = resp_data; o.hit = resp_hit; o.err = resp_err;
        end
      end
      if (mem_req_valid) begin
        if (mseen == 0) o.mreq_addr = mem_req_addr;
        else if (mem_req_addr !== o.mreq_addr) o.mreq_stable = 0;
        mseen++;
        if (mseen > rdy_lat) begin mem_req_ready = 1'b1; acc_pending = 1; end
        else if (noise) begin mem_resp_valid = 1'b1; mem_resp_data = $urandom; end
      end
      if (j >= 0 && mdly > 0 && j == mdly - 1) begin
        mem_resp_valid = 1'b1; mem_resp_data = mdata;
      end
      cache_data_out = arr_rd(cache_addr_out);
      if (o.lat >= 0 && k >= o.lat + 1) break;
    end
    o.mreq_n = mseen;
    mem_resp_valid = 1'b0; mem_req_ready = 1'b0; inv = 1'b0;
  endtask

  task automatic pulse_inv();
    inv = 1'b1;
    @(posedge clk); #1;
    inv = 1'b0;
    m_tag.delete(); m_data.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (req_ready !== 1'b1) begin
      bad++; $display("FAIL reset_req_ready: got %b want 1", req_ready);
    end
    total++;
    if ({resp_valid, resp_data, resp_hit, resp_err, cache_we, cache_addr_in, cache_data_in,
         cache_addr_out, mem_req_valid, mem_req_addr, hit_count, miss_count} !== '0) begin
      bad++; $display("FAIL reset_outputs: got nonzero outputs (resp_valid=%b we=%b mreq=%b hits=%0d misses=%0d) want all 0",
                      resp_valid, cache_we, mem_req_valid, hit_count, miss_count);
    end
  endtask

  task automatic test_first_miss();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    m_apply(32'h0000_1000, 0, 3, 32'hDEADBEEF, 0, eh, ee, ed, el);
    run_req(32'h0000_1000, 0, 3, 32'hDEADBEEF, 0, 0, o);
    total++;
    if (o.lat != el || o.resp_n != 1) begin
      bad++; $display("FAIL miss_latency: got lat=%0d pulses=%0d want lat=%0d pulses=1", o.lat, o.resp_n, el);
    end
    total++;
    if ({o.data, o.hit, o.err} !== {32'hDEADBEEF, 1'b0, 1'b0}) begin
      bad++; $display("FAIL miss_resp: got data=%h hit=%b err=%b want data=deadbeef hit=0 err=0", o.data, o.hit, o.err);
    end
    total++;
    if (o.we_n != 1 || o.we_addr !== 32'h0000_1000 || o.we_data !== 32'hDEADBEEF) begin
      bad++; $display("FAIL miss_fill: got n=%0d addr=%h data=%h want n=1 addr=00001000 data=deadbeef",
                      o.we_n, o.we_addr, o.we_data);
    end
    total++;
    if (miss_count !== 16'd1 || hit_count !== 16'd0) begin
      bad++; $display("FAIL miss_counters: got miss=%0d hit=%0d want miss=1 hit=0", miss_count, hit_count);
    end
  endtask

  task automatic test_repeat_hit();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    m_apply(32'h0000_1000, 0, 2, 32'h1111_1111, 0, eh, ee, ed, el);
    run_req(32'h0000_1000, 0, 2, 32'h1111_1111, 1, 0, o);
    total++;
    if (o.lat != 1 || o.resp_n != 1) begin
      bad++; $display("FAIL hit_latency: got lat=%0d pulses=%0d want lat=1 pulses=1", o.lat, o.resp_n);
    end
    total++;
    if ({o.data, o.hit, o.err} !== {32'hDEADBEEF, 1'b1, 1'b0}) begin
      bad++; $display("FAIL hit_resp: got data=%h hit=%b err=%b want data=deadbeef hit=1 err=0", o.data, o.hit, o.err);
    end
    total++;
    if (o.mreq_n != 0 || o.we_n != 0 || hit_count !== 16'd1) begin
      bad++; $display("FAIL hit_side_effects: got mreq=%0d we=%0d hits=%0d want 0 0 1", o.mreq_n, o.we_n, hit_count);
    end
  endtask

  task automatic test_conflict();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    logic [31:0] b;
    b = 32'h0000_2000;
    for (int i = 0; i < 4096 && ref_idx(b) != ref_idx(32'h0000_1000); i++) b = b + 32'd4;
    total++;
    if (ref_idx(b) != ref_idx(32'h0000_1000)) begin
      bad++; $display("FAIL conflict_search: got idx=%0d want idx=%0d", ref_idx(b), ref_idx(32'h0000_1000));
    end
    m_apply(b, 1, 2, 32'hB0B0_0002, 0, eh, ee, ed, el);
    run_req(b, 1, 2, 32'hB0B0_0002, 0, 0, o);
    total++;
    if (o.hit !== 1'b0 || o.data !== 32'hB0B0_0002) begin
      bad++; $display("FAIL conflict_fill_b: got hit=%b data=%h want hit=0 data=b0b00002", o.hit, o.data);
    end
    m_apply(32'h0000_1000, 0, 1, 32'hA0A0_0003, 0, eh, ee, ed, el);
    run_req(32'h0000_1000, 0, 1, 32'hA0A0_0003, 0, 0, o);
    total++;
    if ({o.hit, o.err, o.data} !== {1'b0, 1'b0, 32'hA0A0_0003} || o.mreq_n != 1 || o.lat != 4) begin
      bad++; $display("FAIL conflict_evicted: got hit=%b err=%b data=%h mreq=%0d lat=%0d want hit=0 err=0 data=a0a00003 mreq=1 lat=4",
                      o.hit, o.err, o.data, o.mreq_n, o.lat);
    end
  endtask

  task automatic test_backpressure();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    m_apply(32'h0BAD_F00C, 5, 2, 32'h5555_AAAA, 0, eh, ee, ed, el);
    run_req(32'h0BAD_F00C, 5, 2, 32'h5555_AAAA, 1, 0, o);
    total++;
    if (o.mreq_n != 6 || !o.mreq_stable || o.mreq_addr !== 32'h0BAD_F00C) begin
      bad++; $display("FAIL backpressure_hold: got cycles=%0d stable=%0d addr=%h want cycles=6 stable=1 addr=0badf00c",
                      o.mreq_n, o.mreq_stable, o.mreq_addr);
    end
    total++;
    if (o.lat != el || o.data !== ed) begin
      bad++; $display("FAIL backpressure_resp: got lat=%0d data=%h want lat=%0d data=%h", o.lat, o.data, el, ed);
    end
  endtask

  task automatic test_timeout();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    // Memory answering on the last allowed wait cycle still fills.
    m_apply(32'h0000_7770, 0, TO, 32'h7777_0000, 0, eh, ee, ed, el);
    run_req(32'h0000_7770, 0, TO, 32'h7777_0000, 0, 0, o);
    total++;
    if ({o.err, o.data} !== {1'b0, 32'h7777_0000} || o.we_n != 1) begin
      bad++; $display("FAIL timeout_edge_ok: got err=%b data=%h we=%0d want err=0 data=77770000 we=1", o.err, o.data, o.we_n);
    end
    m_apply(32'h0000_3330, 0, 0, 32'h0, 0, eh, ee, ed, el);
    run_req(32'h0000_3330, 0, 0, 32'h0, 0, 0, o);
    total++;
    if ({o.err, o.hit, o.data} !== {1'b1, 1'b0, 32'h0} || o.lat != 2 + TO || o.we_n != 0) begin
      bad++; $display("FAIL timeout_resp: got err=%b hit=%b data=%h lat=%0d we=%0d want err=1 hit=0 data=0 lat=%0d we=0",
                      o.err, o.hit, o.data, o.lat, o.we_n, 2 + TO);
    end
    m_apply(32'h0000_3330, 0, 2, 32'h3333_0001, 0, eh, ee, ed, el);
    run_req(32'h0000_3330, 0, 2, 32'h3333_0001, 0, 0, o);
    total++;
    if (o.hit !== 1'b0 || o.mreq_n != 1 || o.data !== 32'h3333_0001) begin
      bad++; $display("FAIL timeout_then_miss: got hit=%b mreq=%0d data=%h want hit=0 mreq=1 data=33330001", o.hit, o.mreq_n, o.data);
    end
  endtask

  task automatic test_inv();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    logic [31:0] y;
    pulse_inv();
    m_apply(32'h0000_1000, 0, 1, 32'hC0DE_0001, 0, eh, ee, ed, el);
    run_req(32'h0000_1000, 0, 1, 32'hC0DE_0001, 0, 0, o);
    total++;
    if (o.hit !== 1'b0 || o.mreq_n != 1) begin
      bad++; $display("FAIL inv_miss: got hit=%b mreq=%0d want hit=0 mreq=1", o.hit, o.mreq_n);
    end
    // Fill of x coincides with inv: x stays resident, y (another slot) is dropped.
    y = 32'h0000_4000;
    for (int i = 0; i < 4096 && ref_idx(y) == ref_idx(32'h0000_5000); i++) y = y + 32'd4;
    m_apply(y, 0, 1, 32'hEEEE_0001, 0, eh, ee, ed, el);
    run_req(y, 0, 1, 32'hEEEE_0001, 0, 0, o);
    m_apply(32'h0000_5000, 0, 1, 32'h5000_0005, 1, eh, ee, ed, el);
    run_req(32'h0000_5000, 0, 1, 32'h5000_0005, 0, 1, o);
    m_apply(32'h0000_5000, 0, 1, 32'h0, 0, eh, ee, ed, el);
    run_req(32'h0000_5000, 0, 1, 32'h0, 0, 0, o);
    total++;
    if ({o.hit, o.data} !== {1'b1, 32'h5000_0005}) begin
      bad++; $display("FAIL inv_fill_wins: got hit=%b data=%h want hit=1 data=50000005", o.hit, o.data);
    end
    m_apply(y, 0, 1, 32'hEEEE_0002, 0, eh, ee, ed, el);
    run_req(y, 0, 1, 32'hEEEE_0002, 0, 0, o);
    total++;
    if (o.hit !== 1'b0 || o.data !== 32'hEEEE_0002) begin
      bad++; $display("FAIL inv_other_cleared: got hit=%b data=%h want hit=0 data=eeee0002", o.hit, o.data);
    end
  endtask

  task automatic test_random();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    logic [31:0] pool [12];
    logic [31:0] a, md;
    int rdy, mdly;
    bit noise, invf;
    for (int i = 0; i < 12; i++) pool[i] = $urandom;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 9) == 0) pulse_inv();
      a     = pool[$urandom_range(0, 11)];
      rdy   = $urandom_range(0, 3);
      mdly  = $urandom_range(0, TO + 1);
      md    = $urandom;
      noise = $urandom_range(0, 1) == 1;
      invf  = $urandom_range(0, 7) == 0;
      m_apply(a, rdy, mdly, md, invf, eh, ee, ed, el);
      run_req(a, rdy, mdly, md, noise, invf, o);
      total++;
      if ({o.hit, o.err, o.data} !== {eh, ee, ed} || o.lat != el || o.resp_n != 1) begin
        bad++; $display("FAIL rand_resp[%0d]: got hit=%b err=%b data=%h lat=%0d pulses=%0d want hit=%b err=%b data=%h lat=%0d pulses=1",
                        n, o.hit, o.err, o.data, o.lat, o.resp_n, eh, ee, ed, el);
      end
      total++;
      if (o.we_n != ((!eh && !ee) ? 1 : 0) || (o.we_n == 1 && {o.we_addr, o.we_data} !== {a, md})) begin
        bad++; $display("FAIL rand_fill[%0d]: got n=%0d addr=%h data=%h want n=%0d addr=%h data=%h",
                        n, o.we_n, o.we_addr, o.we_data, (!eh && !ee) ? 1 : 0, a, md);
      end
      total++;
      if (o.mreq_n != (eh ? 0 : rdy + 1) || !o.mreq_stable || (!eh && o.mreq_addr !== a)) begin
        bad++; $display("FAIL rand_memreq[%0d]: got cycles=%0d stable=%0d addr=%h want cycles=%0d addr=%h",
                        n, o.mreq_n, o.mreq_stable, o.mreq_addr, eh ? 0 : rdy + 1, a);
      end
      total++;
      if (hit_count !== 16'(m_hits) || miss_count !== 16'(m_misses) || req_ready !== 1'b1) begin
        bad++; $display("FAIL rand_counters[%0d]: got hit=%0d miss=%0d ready=%b want hit=%0d miss=%0d ready=1",
                        n, hit_count, miss_count, req_ready, m_hits, m_misses);
      end
    end
  endtask

  task automatic test_reset_midflight();
    obs_t o; bit eh, ee; logic [31:0] ed; int el;
    int seen;
    // Make sure a known address is resident before the reset.
    m_apply(32'h0000_9000, 0, 1, 32'h9999_0000, 0, eh, ee, ed, el);
    run_req(32'h0000_9000, 0, 1, 32'h9999_0000, 0, 0, o);
    req_valid = 1'b1; req_addr = 32'hFEED_0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (mem_req_valid !== 1'b1) begin
      bad++; $display("FAIL midflight_memreq: got %b want 1", mem_req_valid);
    end
    @(posedge clk); #1;
    mem_req_ready = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_tag.delete(); m_data.delete(); m_hits = 0; m_misses = 0;
    total++;
    if (req_ready !== 1'b1 || hit_count !== 16'd0 || miss_count !== 16'd0) begin
      bad++; $display("FAIL midflight_reset_state: got ready=%b hit=%0d miss=%0d want ready=1 hit=0 miss=0",
                      req_ready, hit_count, miss_count);
    end
    // A late memory reply must not revive the abandoned transaction.
    seen = 0;
    mem_resp_valid = 1'b1; mem_resp_data = 32'hBADD_A7A0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      mem_resp_valid = 1'b0;
      if (resp_valid || cache_we) seen++;
    end
    total++;
    if (seen != 0) begin
      bad++; $display("FAIL midflight_no_resp: got %0d response/fill cycles want 0", seen);
    end
    m_apply(32'h0000_9000, 0, 1, 32'h9999_0001, 0, eh, ee, ed, el);
    run_req(32'h0000_9000, 0, 1, 32'h9999_0001, 0, 0, o);
    total++;
    if (o.hit !== 1'b0 || o.data !== 32'h9999_0001 || miss_count !== 16'd1) begin
      bad++; $display("FAIL midflight_tags_cleared: got hit=%b data=%h miss=%0d want hit=0 data=99990001 miss=1",
                      o.hit, o.data, miss_count);
    end
  endtask

  initial begin
    test_reset();
    test_first_miss();
    test_repeat_hit();
    test_conflict();
    test_backpressure();
    test_timeout();
    test_inv();
    test_random();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/l2k_cache_fill.md
Name: l2k_cache_fill

Overview:
- Request-side controller for the hashed direct-mapped L2 data array (write port: we/addr_in/data_in; combinational read port: addr_out/data_out).
- Accepts single-word read requests from the core and tracks tag/valid per slot.
- On a hit, returns the array data. On a miss, fetches the word from memory over a valid/ready handshake, writes it into the array, then responds.
- Sits between the core load path, the L2 array and the memory bus.

Parameters:
- DATA_WIDTH, 32, width of a cached word.
- NUM_ENTRIES, 512, number of slots; must be a power of 2; IDX_W = log2(NUM_ENTRIES).
- TIMEOUT, 255, maximum MEM_WAIT cycles before an error response; range 1..65535.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  core read request
- req_addr  in  32  request address
- req_ready  out  1  high only in IDLE
- resp_valid  out  1  one-cycle response pulse
- resp_data  out  DATA_WIDTH  response word
- resp_hit  out  1  response was a hit
- resp_err  out  1  memory timeout, resp_data=0
- inv  in  1  invalidate all tags
- cache_we  out  1  array write enable
- cache_addr_in  out  32  array write address
- cache_data_in  out  DATA_WIDTH  array write data
- cache_addr_out  out  32  array read address
- cache_data_out  in  DATA_WIDTH  array read data (combinational)
- mem_req_valid  out  1  memory read request
- mem_req_addr  out  32  memory read address
- mem_req_ready  in  1  memory accepts request
- mem_resp_valid  in  1  memory data valid
- mem_resp_data  in  DATA_WIDTH  memory data
- hit_count  out  16  saturating hit counter
- miss_count  out  16  saturating miss counter

Behaviour:
- Slot index: idx(x) = low IDX_W bits of h, computed in 32-bit arithmetic with products truncated to 32 bits:
  - x1 = ((x>>16)^x)*0x045D9F3B
  - x2 = ((x1>>16)^x1)*0x045D9F3B
  - h = (x2>>16)^x2
- Internal tag store: NUM_ENTRIES x {valid, 32-bit full address}.
- Reset: state=IDLE, all tag valid bits cleared, counters cleared. Every output is 0 except req_ready=1. Reset mid-transaction abandons it silently: no fill and no response.
- IDLE:
  - req_ready=1.
  - req_valid & req_ready latches req_addr into A, then goes to LOOKUP.
- LOOKUP:
  - cache_addr_out=A.
  - Hit when valid[idx(A)] and tag[idx(A)]==A: latch D=cache_data_out, hit_count++, go to RESP with hit=1.
  - Otherwise miss_count++ and go to MEM_REQ.
- MEM_REQ:
  - mem_req_valid=1, mem_req_addr=A.
  - Both stay held until mem_req_ready is sampled high; then go to MEM_WAIT and clear the wait counter.
- MEM_WAIT:
  - On mem_resp_valid: D=mem_resp_data, go to FILL.
  - Otherwise increment the counter. When the counter reaches TIMEOUT, go to RESP with err=1, D=0, and no fill or tag update.
- FILL:
  - cache_we=1 for exactly one cycle, with cache_addr_in=A, cache_data_in=D.
  - tag[idx(A)]=A, valid=1.
  - Go to RESP with hit=0.
- RESP:
  - resp_valid=1 for one cycle with resp_data/resp_hit/resp_err. There is no backpressure.
  - Next state is IDLE.
- Outside their states, cache_we, mem_req_valid and resp_valid are 0. resp_hit and resp_err are 0 when resp_valid=0.
- Hit latency: acceptance edge N, resp_valid high in cycle N+2.
- Minimum miss latency, with mem_req_ready already high and a one-cycle memory: resp_valid at N+5.
- inv:
  - Clears all valid bits at the next edge, in any state.
  - If inv coincides with FILL, the filled slot ends valid (fill wins). All other slots are cleared.
- mem_resp_valid outside MEM_WAIT is ignored.
- Conflicting addresses (same idx, different A) evict the previous tag. A later request to the evicted address misses.
- Counters saturate at 0xFFFF.

Test Plan:
- Reset then request A=0x00001000; memory returns 0xDEADBEEF after 3 cycles -> one cache_we pulse at 0x00001000/0xDEADBEEF; resp_valid with data=0xDEADBEEF, hit=0; miss_count=1.
- Repeat request 0x00001000 -> resp_valid at N+2, data=0xDEADBEEF, hit=1, no mem_req_valid; hit_count=1.
- Bench computes two addresses with equal idx; fill both, then re-request the first -> miss, memory fetch, response data from memory, hit=0.
- Hold mem_req_ready low 5 cycles -> mem_req_valid and mem_req_addr stay stable throughout; proceeds on the first cycle ready is high.
- TIMEOUT=4, memory never responds -> resp_valid with err=1, data=0, no cache_we; next request to the same address misses.
- Pulse inv after a fill, then re-request -> miss. Assert rst during MEM_WAIT -> no response, req_ready=1 the next cycle, counters=0.
